time_parameters: RTL and testbench
==================================

Name: time_parameters

Overview:
- Storage and lookup block for the traffic-light controller's timing intervals.
- Holds three programmable 4-bit durations: BASE, EXTENDED and YELLOW.
- Outputs the duration chosen by the FSM's interval code on `value`.
- Registers are reloaded with factory defaults on reset and can be reprogrammed from the front-panel selector/value switches via a synchronized program strobe.

Parameters:
- WIDTH, 4, bit width of each time parameter and of time_value/value
- DEF_BASE, 6, default BASE interval (4'b0110)
- DEF_EXT, 3, default EXTENDED interval (4'b0011)
- DEF_YEL, 2, default YELLOW interval (4'b0010)

Ports:
- clock  input  1  system clock, rising-edge active
- reset_sync  input  1  reset, asynchronous, active-high; restores all defaults
- prog_sync  input  1  program strobe, already synchronized to clock, active-high
- interval  input  2  read select: 00=BASE, 01=EXTENDED, 10=YELLOW, 11=unused
- time_param_selector  input  2  write select: 00=BASE, 01=EXTENDED, 10=YELLOW, 11=none
- time_value  input  WIDTH  new value to program
- value  output  WIDTH  duration for the currently selected interval

Behaviour:
- One clock; reset is asynchronous and active-high (reset_sync). Interface signals clock, reset_sync, prog_sync, interval, time_param_selector, time_value, value.
- State: three WIDTH-bit registers: base_r, ext_r, yel_r.
- Reset:
  - While reset_sync=1, immediately and regardless of clock: base_r=DEF_BASE, ext_r=DEF_EXT, yel_r=DEF_YEL.
  - Reset dominates prog_sync.
  - value therefore reads 6/3/2 for interval 00/01/10 during and after reset.
- Programming:
  - On a rising clock edge with reset_sync=0 and prog_sync=1, the register addressed by time_param_selector loads time_value.
  - Zero rule: if time_value==0, the addressed register instead loads its own default (BASE to 6, EXT to 3, YEL to 2). A zero duration is never stored.
  - time_param_selector=11: no register changes.
  - Only the addressed register changes; the others hold.
  - prog_sync held high for multiple cycles rewrites every cycle (idempotent for static inputs).
  - prog_sync=0: all registers hold.
- Readout:
  - value is a combinational mux of the registers by interval, with zero latency on an interval change.
  - 00 gives base_r, 01 gives ext_r, 10 gives yel_r, 11 gives 0.
  - A programmed value is visible on value from the rising edge that captures it (one-cycle write latency).
- Simultaneous events:
  - Reading and writing the same parameter on one edge: value shows the old content before the edge and the new content after it.
  - Reset asserted mid-operation: immediate return to defaults.
- Values 1..15 are accepted unchanged; there is no saturation or wrap.

Test Plan:
- Assert reset_sync=1 for 3 cycles, then sweep interval 00/01/10/11 -> value=6, 3, 2, 0 respectively (both during and after reset).
- Release reset, set selector=01, time_value=10, pulse prog_sync for 1 cycle, interval=01 -> value=10; interval=00 -> 6; interval=10 -> 2 (others unchanged).
- Selector=01, time_value=0, pulse prog_sync -> ext_r reloads default; interval=01 gives value=3.
- After programming EXT=10, assert reset_sync asynchronously between clock edges with interval=01 -> value returns to 3 before the next clock edge; reset with prog_sync high simultaneously -> defaults retained.
- Selector=11, time_value=9, prog_sync high for 3 cycles -> value unchanged for interval 00/01/10 (6/3/2); selector=10, time_value=15, prog_sync held 2 cycles -> interval=10 gives 15.
- Program BASE=4 while interval=00 -> value changes from 6 to 4 exactly at the capturing edge, with no glitch to another parameter.

Source files
------------

// File: rtl/time_parameters.sv
// Programmable BASE/EXTENDED/YELLOW durations for the traffic-light FSM, read back by interval code.
// Writes land on the capturing clock edge; readout is a zero-latency combinational mux.
module time_parameters #(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] DEF_BASE = WIDTH'(6),
  parameter logic [WIDTH-1:0] DEF_EXT  = WIDTH'(3),
  parameter logic [WIDTH-1:0] DEF_YEL  = WIDTH'(2)
) (
  input  logic             clock,
  input  logic             reset_sync,
  input  logic             prog_sync,
  input  logic [1:0]       interval,
  input  logic [1:0]       time_param_selector,
  input  logic [WIDTH-1:0] time_value,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] ext_q,  ext_d;
  logic [WIDTH-1:0] yel_q,  yel_d;
  logic             zero_val;

  assign zero_val = (time_value == '0);

  // A zero duration would stall the light, so a zero write restores that register's default.
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (prog_sync) begin
      case (time_param_selector)
        2'b00:   base_d = zero_val ? DEF_BASE : time_value;
        2'b01:   ext_d  = zero_val ? DEF_EXT  : time_value;
        2'b10:   yel_d  = zero_val ? DEF_YEL  : time_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      base_q <= DEF_BASE;
      ext_q  <= DEF_EXT;
      yel_q  <= DEF_YEL;
    end else begin
      base_q <= base_d;
      ext_q  <= ext_d;
      yel_q  <= yel_d;
    end
  end

  always_comb begin
    value = '0;
    case (interval)
      2'b00:   value = base_q;
      2'b01:   value = ext_q;
      2'b10:   value = yel_q;
      default: value = '0;
    endcase
  end

endmodule

// File: tb/tb_time_parameters.sv
// Bench for time_parameters: reset sweep, vector table, hand-written edge cases, random vs. model.
module tb_time_parameters;

  logic       clock;
  logic       reset_sync;
  logic       prog_sync;
  logic [1:0] interval;
  logic [1:0] time_param_selector;
  logic [3:0] time_value;
  logic [3:0] value;

  int n_checks = 0;
  int n_fail   = 0;

  time_parameters dut (
    .clock               (clock),
    .reset_sync          (reset_sync),
    .prog_sync           (prog_sync),
    .interval            (interval),
    .time_param_selector (time_param_selector),
    .time_value          (time_value),
    .value               (value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       prog;
    logic [1:0] sel;
    logic [3:0] tv;
    logic [1:0] iv;
    logic [3:0] exp_after;
  } vec_t;

  vec_t vecs[15];

  // Reference model: three durations in an array, indexed by the interval code.
  int defs[3]  = '{6, 3, 2};
  int model[3] = '{6, 3, 2};

  function automatic int model_read(input int iv);
    return (iv == 3) ? 0 : model[iv];
  endfunction

  task automatic model_write(input bit prog, input int sel, input int tv);
    if (prog && sel != 3) model[sel] = (tv == 0) ? defs[sel] : tv;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) model[i] = defs[i];
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: value=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic [1:0] s, input logic [3:0] tv, input logic [1:0] iv);
    prog_sync           = p;
    time_param_selector = s;
    time_value          = tv;
    interval            = iv;
  endtask

  logic [3:0] exp_def[4];

  initial begin
    exp_def[0] = 4'd6; exp_def[1] = 4'd3; exp_def[2] = 4'd2; exp_def[3] = 4'd0;

    vecs[0]  = '{1'b1, 2'b01, 4'd10, 2'b01, 4'd10};
    vecs[1]  = '{1'b0, 2'b01, 4'd10, 2'b00, 4'd6};
    vecs[2]  = '{1'b0, 2'b01, 4'd10, 2'b10, 4'd2};
    vecs[3]  = '{1'b0, 2'b01, 4'd10, 2'b11, 4'd0};
    vecs[4]  = '{1'b1, 2'b01, 4'd0,  2'b01, 4'd3};
    vecs[5]  = '{1'b1, 2'b11, 4'd9,  2'b00, 4'd6};
    vecs[6]  = '{1'b1, 2'b11, 4'd9,  2'b01, 4'd3};
    vecs[7]  = '{1'b1, 2'b11, 4'd9,  2'b10, 4'd2};
    vecs[8]  = '{1'b1, 2'b10, 4'd15, 2'b10, 4'd15};
    vecs[9]  = '{1'b1, 2'b10, 4'd15, 2'b10, 4'd15};
    vecs[10] = '{1'b1, 2'b00, 4'd1,  2'b00, 4'd1};
    vecs[11] = '{1'b0, 2'b00, 4'd5,  2'b00, 4'd1};
    vecs[12] = '{1'b1, 2'b00, 4'd0,  2'b00, 4'd6};
    vecs[13] = '{1'b1, 2'b01, 4'd15, 2'b00, 4'd6};
    vecs[14] = '{1'b0, 2'b01, 4'd15, 2'b01, 4'd15};

    // Reset held 3 cycles, with a program attempt that must be ignored.
    reset_sync = 1'b1;
    drive(1'b1, 2'b00, 4'd9, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      interval = 2'(i);
      #1 check("reset_during", value, exp_def[i]);
    end
    @(negedge clock);
    interval = 2'b11;
    #1 check("reset_during_iv3", value, exp_def[3]);
    @(posedge clock);
    interval = 2'b00;
    #1 check("reset_dominates_prog", value, 4'd6);

    @(negedge clock);
    reset_sync = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      interval = 2'(i);
      #1 check("after_reset", value, exp_def[i]);
    end

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      drive(vecs[i].prog, vecs[i].sel, vecs[i].tv, vecs[i].iv);
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), value, vecs[i].exp_after);
    end

    // Asynchronous reset between edges returns EXT to its default before the next edge.
    @(negedge clock);
    drive(1'b1, 2'b01, 4'd10, 2'b01);
    @(posedge clock);
    #1 check("ext_prog_10", value, 4'd10);
    prog_sync = 1'b0;
    #2 reset_sync = 1'b1;
    #1 check("async_reset_immediate", value, 4'd3);
    prog_sync = 1'b1;
    @(posedge clock);
    #1 check("async_reset_with_prog", value, 4'd3);
    @(negedge clock);
    reset_sync = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 2'b00);

    // Same-edge read/write of BASE: old value until the capturing edge, new value after.
    @(negedge clock);
    drive(1'b1, 2'b00, 4'd4, 2'b00);
    #1 check("rw_before_edge", value, 4'd6);
    #3 check("rw_just_before_edge", value, 4'd6);
    @(posedge clock);
    #1 check("rw_after_edge", value, 4'd4);
    @(negedge clock);
    prog_sync = 1'b0;
    #1 check("rw_hold", value, 4'd4);

    // Random traffic against the model, including occasional asynchronous resets.
    reset_sync = 1'b1;
    @(negedge clock);
    reset_sync = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic       r, p;
      logic [1:0] s, iv;
      logic [3:0] tv;
      @(negedge clock);
      r  = ($urandom_range(0, 29) == 0);
      p  = ($urandom_range(0, 2) != 0);
      s  = 2'($urandom_range(0, 3));
      iv = 2'($urandom_range(0, 3));
      tv = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      drive(p, s, tv, iv);
      reset_sync = r;
      if (r) model_reset();
      #1 check("rand_pre", value, 4'(model_read(int'(iv))));
      @(posedge clock);
      if (!r) model_write(p, int'(s), int'(tv));
      #1 check("rand_post", value, 4'(model_read(int'(iv))));
    end
    reset_sync = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
